// File: rtl/axi_bram_log_drain.sv
// axi_bram_log_drain: drains entries from the BRAM logger's 32-bit external
// port, rebuilds each NUM_PAR_BRAMS-word entry and streams it out on a
// valid/ready interface, then pulses the logger's clear and reports done.
//
// Ports:
//   Clk_CI, Rst_RI            clock, async active-high reset
//   Start_SI, NumEntries_DI   start pulse and entry count (clamped to CAP)
//   Full_SI                   logger full flag (auto-start, LOG_DRAIN_AUTO_EN)
//   Busy_SO, Done_SO          busy level, one-cycle done pulse
//   Clear_SO                  one-cycle clear pulse to the logger
//   BramEn_SO, BramAddr_DO    BRAM read port (byte address)
//   BramWrEn_SO, BramWr_DO    BRAM write port, tied off
//   BramRd_DI                 BRAM read data, one cycle after the address
//   LogValid_SO, LogReady_SI  entry stream handshake
//   LogData_DO                entry, word p at bits [32p+31:32p]
//
// Optional build macro: LOG_DRAIN_AUTO_EN (rising edge of Full_SI in IDLE
// starts a full-capacity drain; Start_SI wins when both occur together).

module axi_bram_log_drain #(
    parameter int NUM_PAR_BRAMS  = 3,
    parameter int NUM_SER_BRAMS  = 12,
    parameter int ENTRY_CNT_BITW = 14,
    parameter int BRAM_ADDR_BITW = 32
) (
    input  logic                        Clk_CI,
    input  logic                        Rst_RI,
    input  logic                        Start_SI,
    input  logic [ENTRY_CNT_BITW-1:0]   NumEntries_DI,
    input  logic                        Full_SI,
    output logic                        Busy_SO,
    output logic                        Done_SO,
    output logic                        Clear_SO,
    output logic                        BramEn_SO,
    output logic [BRAM_ADDR_BITW-1:0]   BramAddr_DO,
    output logic [3:0]                  BramWrEn_SO,
    output logic [31:0]                 BramWr_DO,
    input  logic [31:0]                 BramRd_DI,
    output logic                        LogValid_SO,
    input  logic                        LogReady_SI,
    output logic [32*NUM_PAR_BRAMS-1:0] LogData_DO
);

    localparam int CAP       = 1024 * NUM_SER_BRAMS;
    localparam int WIDX_BITW = (NUM_PAR_BRAMS > 1) ? $clog2(NUM_PAR_BRAMS) : 1;

    localparam logic [ENTRY_CNT_BITW-1:0] CapC     = ENTRY_CNT_BITW'(CAP);
    localparam logic [WIDX_BITW-1:0]      LastWord = WIDX_BITW'(NUM_PAR_BRAMS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_COLLECT,
        S_OUT,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [ENTRY_CNT_BITW-1:0]   entry_q, entry_d;
    logic [WIDX_BITW-1:0]        word_q, word_d;
    logic [ENTRY_CNT_BITW-1:0]   num_q, num_d;
    logic                        cap_vld_q;
    logic [WIDX_BITW-1:0]        cap_idx_q;
    logic [32*NUM_PAR_BRAMS-1:0] data_q;

    logic [ENTRY_CNT_BITW-1:0]   num_clamped;
    logic                        start_req;
    logic [ENTRY_CNT_BITW-1:0]   start_num;
    logic [BRAM_ADDR_BITW-1:0]   word_addr;

    assign num_clamped = (NumEntries_DI > CapC) ? CapC : NumEntries_DI;

`ifdef LOG_DRAIN_AUTO_EN
    logic full_q;

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            full_q <= 1'b0;
        end else begin
            full_q <= Full_SI;
        end
    end

    // Explicit start keeps its own count even if Full_SI rises together.
    assign start_req = Start_SI | (Full_SI & ~full_q);
    assign start_num = Start_SI ? num_clamped : CapC;
`else
    logic unused_full;

    assign unused_full = Full_SI;
    assign start_req   = Start_SI;
    assign start_num   = num_clamped;
`endif

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            state_q <= S_IDLE;
            entry_q <= '0;
            word_q  <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            word_q  <= word_d;
            num_q   <= num_d;
        end
    end

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        word_d  = word_q;
        num_d   = num_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    num_d   = start_num;
                    entry_d = '0;
                    word_d  = '0;
                    state_d = (start_num == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (word_q == LastWord) begin
                    word_d  = '0;
                    state_d = S_COLLECT;
                end else begin
                    word_d = word_q + 1'b1;
                end
            end
            S_COLLECT: state_d = S_OUT;
            S_OUT: begin
                if (LogReady_SI) begin
                    if (entry_q == num_q - 1'b1) begin
                        state_d = S_CLEAR;
                    end else begin
                        entry_d = entry_q + 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            S_CLEAR: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read data arrives one cycle after its address, so the slot index
    // is delayed alongside a capture strobe.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
            data_q    <= '0;
        end else begin
            cap_vld_q <= (state_q == S_READ);
            cap_idx_q <= word_q;
            for (int p = 0; p < NUM_PAR_BRAMS; p++) begin
                if (cap_vld_q && cap_idx_q == WIDX_BITW'(p)) begin
                    data_q[32*p +: 32] <= BramRd_DI;
                end
            end
        end
    end

    assign word_addr = BRAM_ADDR_BITW'(entry_q) * BRAM_ADDR_BITW'(NUM_PAR_BRAMS)
                     + BRAM_ADDR_BITW'(word_q);

    // Outputs decode the state directly so an async reset clears them at once.
    assign Busy_SO     = (state_q != S_IDLE);
    assign Done_SO     = (state_q == S_DONE);
    assign Clear_SO    = (state_q == S_CLEAR);
    assign BramEn_SO   = (state_q == S_READ);
    assign BramAddr_DO = (state_q == S_READ) ? (word_addr << 2) : '0;
    assign BramWrEn_SO = 4'h0;
    assign BramWr_DO   = 32'h0;
    assign LogValid_SO = (state_q == S_OUT);
    assign LogData_DO  = data_q;

endmodule

// File: tb/tb_axi_bram_log_drain.sv
// tb_axi_bram_log_drain: table-driven and randomized bench for
// axi_bram_log_drain with a BRAM model and entry-level reference model.

module tb_axi_bram_log_drain;

    localparam int NPAR = 3;
    localparam int CAP  = 12288;

    localparam int M_ALWAYS = 0;
    localparam int M_STALL  = 1;
    localparam int M_RAND   = 2;

    logic        Clk_CI = 1'b0;
    logic        Rst_RI;
    logic        Start_SI;
    logic [13:0] NumEntries_DI;
    logic        Full_SI;
    logic        Busy_SO;
    logic        Done_SO;
    logic        Clear_SO;
    logic        BramEn_SO;
    logic [31:0] BramAddr_DO;
    logic [3:0]  BramWrEn_SO;
    logic [31:0] BramWr_DO;
    logic [31:0] BramRd_DI;
    logic        LogValid_SO;
    logic        LogReady_SI;
    logic [95:0] LogData_DO;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [13:0] num;
        int          mode;
        int          exp_n;
        bit          restart;
    } vec_t;

    always #5 Clk_CI = ~Clk_CI;

    axi_bram_log_drain dut (
        .Clk_CI        (Clk_CI),
        .Rst_RI        (Rst_RI),
        .Start_SI      (Start_SI),
        .NumEntries_DI (NumEntries_DI),
        .Full_SI       (Full_SI),
        .Busy_SO       (Busy_SO),
        .Done_SO       (Done_SO),
        .Clear_SO      (Clear_SO),
        .BramEn_SO     (BramEn_SO),
        .BramAddr_DO   (BramAddr_DO),
        .BramWrEn_SO   (BramWrEn_SO),
        .BramWr_DO     (BramWr_DO),
        .BramRd_DI     (BramRd_DI),
        .LogValid_SO   (LogValid_SO),
        .LogReady_SI   (LogReady_SI),
        .LogData_DO    (LogData_DO)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] w);
        return (w * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [95:0] model_entry(input int k);
        logic [95:0] e;
        for (int p = 0; p < NPAR; p++) begin
            e[32*p +: 32] = mem_word(32'(NPAR * k + p));
        end
        return e;
    endfunction

    // BRAM: registered read, one cycle latency
    always @(posedge Clk_CI) begin
        if (BramEn_SO) BramRd_DI <= mem_word(BramAddr_DO >> 2);
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic run_drain(input logic [13:0] num, input int mode,
                             input int exp_n, input bit restart);
        int cyc, hs, reads, first_rd, first_vld;
        int clear_cyc, last_hs, done_cyc, vcnt;
        logic [95:0] prev_d;
        bit prev_stall;
        cyc = 0; hs = 0; reads = 0; first_rd = -1; first_vld = -1;
        clear_cyc = -1; last_hs = -1; done_cyc = -1; vcnt = 0;
        prev_stall = 1'b0; prev_d = '0;
        @(negedge Clk_CI);
        NumEntries_DI = num;
        Start_SI = 1'b1;
        LogReady_SI = 1'b0;
        while (done_cyc < 0 && cyc < 10 * exp_n + 60) begin
            @(negedge Clk_CI);
            cyc++;
            Start_SI = restart && (cyc == 7);
            NumEntries_DI = restart ? 14'd1 : num;
            if (LogValid_SO) vcnt++;
            case (mode)
                M_ALWAYS: LogReady_SI = 1'b1;
                M_STALL:  LogReady_SI = (vcnt > 10);
                default:  LogReady_SI = 1'($urandom_range(0, 1));
            endcase
            #1;
            chk("busy", Busy_SO, 1'b1);
            if (prev_stall) begin
                chk("hold_vld", LogValid_SO, 1'b1);
                chk("hold_data", LogData_DO, prev_d);
            end
            if (BramEn_SO) begin
                if (first_rd < 0) first_rd = cyc;
                chk("addr", BramAddr_DO, 32'(reads) * 4);
                chk("rd_ahead", reads < NPAR * (hs + 1), 1'b1);
                chk("no_wr", {BramWrEn_SO, BramWr_DO}, 36'h0);
                reads++;
            end
            if (LogValid_SO) begin
                if (first_vld < 0) first_vld = cyc;
                chk("en_in_out", BramEn_SO, 1'b0);
                if (LogReady_SI) begin
                    chk("data", LogData_DO, model_entry(hs));
                    chk("hs_extra", hs < exp_n, 1'b1);
                    hs++;
                    last_hs = cyc;
                end
            end
            prev_stall = LogValid_SO && !LogReady_SI;
            prev_d = LogData_DO;
            if (Clear_SO) begin
                chk("clr_cnt", hs, exp_n);
                chk("clr_after_hs", last_hs, cyc - 1);
                clear_cyc = cyc;
            end
            if (Done_SO) begin
                done_cyc = cyc;
                if (exp_n == 0) begin
                    chk("done0_lat", cyc, 1);
                    chk("done0_noclr", clear_cyc, -1);
                end else begin
                    chk("done_after_clr", clear_cyc, cyc - 1);
                end
            end
        end
        chk("timeout", done_cyc >= 0, 1'b1);
        chk("reads", reads, NPAR * exp_n);
        chk("entries", hs, exp_n);
        if (exp_n > 0) chk("latency", first_vld - first_rd, 4);
        Start_SI = 1'b0;
        LogReady_SI = 1'b0;
        @(negedge Clk_CI);
        #1;
        chk("idle_after", {Busy_SO, Done_SO, Clear_SO, LogValid_SO}, 4'h0);
    endtask

    task automatic reset_mid_drain();
        int v;
        bit hit;
        v = 0;
        hit = 1'b0;
        @(negedge Clk_CI);
        NumEntries_DI = 14'd6;
        Start_SI = 1'b1;
        LogReady_SI = 1'b1;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge Clk_CI);
            Start_SI = 1'b0;
            if (LogValid_SO) begin
                if (v == 3) hit = 1'b1;
                else v++;
            end
        end
        chk("rst_reach_e3", hit, 1'b1);
        #1 Rst_RI = 1'b1;
        #1;
        chk("rst_ctl", {Busy_SO, Done_SO, Clear_SO, LogValid_SO, BramEn_SO}, 5'h0);
        chk("rst_addr", BramAddr_DO, 32'h0);
        chk("rst_data", LogData_DO, 96'h0);
        @(negedge Clk_CI);
        Rst_RI = 1'b0;
        LogReady_SI = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk_CI);
            #1;
            chk("rst_quiet", {Busy_SO, Clear_SO, BramEn_SO}, 3'h0);
        end
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{num: 14'd2,     mode: M_ALWAYS, exp_n: 2,     restart: 1'b0};
        vecs[1] = '{num: 14'd1,     mode: M_STALL,  exp_n: 1,     restart: 1'b0};
        vecs[2] = '{num: 14'd0,     mode: M_ALWAYS, exp_n: 0,     restart: 1'b0};
        vecs[3] = '{num: 14'd5,     mode: M_RAND,   exp_n: 5,     restart: 1'b1};
        vecs[4] = '{num: 14'd3,     mode: M_STALL,  exp_n: 3,     restart: 1'b0};
        vecs[5] = '{num: 14'd16383, mode: M_ALWAYS, exp_n: CAP,   restart: 1'b0};

        Rst_RI = 1'b1;
        Start_SI = 1'b0;
        NumEntries_DI = '0;
        Full_SI = 1'b0;
        LogReady_SI = 1'b0;
        BramRd_DI = '0;
        #3;
        chk("reset_ctl", {Busy_SO, Done_SO, Clear_SO, LogValid_SO, BramEn_SO}, 5'h0);
        chk("reset_addr", BramAddr_DO, 32'h0);
        chk("reset_data", LogData_DO, 96'h0);
        chk("reset_wr", {BramWrEn_SO, BramWr_DO}, 36'h0);
        repeat (2) @(negedge Clk_CI);
        Rst_RI = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_drain(vecs[i].num, vecs[i].mode, vecs[i].exp_n, vecs[i].restart);
        end

        for (int i = 0; i < 5; i++) begin
            logic [13:0] n;
            int m;
            n = 14'($urandom_range(0, 9));
            m = (i % 2 == 0) ? M_RAND : M_ALWAYS;
            run_drain(n, m, (int'(n) > CAP) ? CAP : int'(n), 1'b0);
        end

        reset_mid_drain();
        run_drain(14'd2, M_RAND, 2, 1'b0);

`ifdef LOG_DRAIN_AUTO_EN
        @(negedge Clk_CI);
        Full_SI = 1'b1;
        @(negedge Clk_CI);
        #1;
        chk("auto_busy", Busy_SO, 1'b1);
        chk("auto_en", BramEn_SO, 1'b1);
        chk("auto_addr", BramAddr_DO, 32'h0);
        Rst_RI = 1'b1;
        Full_SI = 1'b0;
        @(negedge Clk_CI);
        Rst_RI = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
